adder_share_arbiter: RTL

- Shares one combinational 64-bit prefix adder (BrentKung64b-class: A, B in; 65-bit S out) among NREQ requesters.
- Round-robin arbitration, registered adder operands, registered 65-bit result on a single shared response channel with backpressure.
- Sits between several datapath clients and one adder instance. The adder is instantiated outside this block and connected through the add_* ports.

---
 rtl/adder_share_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin share of one external W-bit adder among NREQ requesters.
// Latency: accept at edge T, result registered at T+1, rsp_valid from T+1 until handshake.
// Backpressure: rsp_ready low holds RESP with result stable; no new grants until drained.
module adder_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 64,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W:0]        rsp_sum,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    input  logic [W:0]        add_s,
    output logic              busy,
    output logic [31:0]       op_count
);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] win_id;
    logic           win_vld;
    logic           acc;
    int             idx;

    // Search starts at rr_ptr and wraps with an explicit compare so non-power-of-two NREQ works.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_vld && req_valid[idx]) begin
                win_vld = 1'b1;
                win_id  = IDW'(idx);
            end
        end
    end

    assign acc = (state == IDLE) && win_vld && !rst;

    always_comb begin
        req_ready = '0;
        if (acc) req_ready[win_id] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc) state_nxt = EVAL;
            EVAL:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            grant_id <= '0;
            add_a    <= '0;
            add_b    <= '0;
            rsp_sum  <= '0;
            rsp_id   <= '0;
            op_count <= '0;
        end else begin
            if (acc) begin
                add_a    <= req_a[int'(win_id)*W +: W];
                add_b    <= req_b[int'(win_id)*W +: W];
                grant_id <= win_id;
                rr_ptr   <= (win_id == IDW'(NREQ-1)) ? '0 : win_id + IDW'(1);
            end
            // Operands were registered at acceptance, so add_s has had all of EVAL to settle.
            if (state == EVAL) begin
                rsp_sum <= add_s;
                rsp_id  <= grant_id;
            end
            if (state == RESP && rsp_ready) op_count <= op_count + 32'd1;
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule
